// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the input-conditioning blocks: FSM state encoding
// and the default qualification settings.
package debounce_sync_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/debounce_sync_sync2.sv
// Two-flop synchroniser for a single asynchronous level. Reusable for any
// asynchronous input; the reset value is a parameter.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Next-state of the synchroniser chain
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser flops; clocked every cycle, independent of any enable
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous level. Produces a clean
// registered level plus one-cycle rise/fall pulses and a busy flag while a
// candidate transition is being qualified.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             dout_d, dout_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic             busy_d, busy_q;

  sync2 #(
    .RESET_VAL (RESET_LEVEL)
  ) u_sync2 (
    .clock (clock),
    .reset (reset),
    .d     (din),
    .q     (s2)
  );

  // Qualification FSM: count consecutive mismatching samples, toggle on the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    if (enable) begin
      unique case (state_q)
        ST_STABLE: begin
          if (s2 != dout_q) begin
            if (STABLE_CYCLES == 1) begin
              dout_d = ~dout_q;
            end else begin
              state_d = ST_CHECK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (s2 == dout_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            dout_d  = ~dout_q;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Pulses and busy are decoded from next-state so they register alongside dout
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
    busy_d = (state_d == ST_CHECK);
  end

  // State, counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: STABLE_CYCLES=4 main instance plus a
// STABLE_CYCLES=1 instance for the minimum setting.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic reset, din, enable;
  logic dout, rise, fall, busy;
  logic din1;
  logic dout1, rise1, fall1, busy1;

  int passed = 0;
  int total  = 0;
  int viol_both  = 0;
  int viol_busy1 = 0;
  logic mon_en = 1'b0;

  always #10 clk = ~clk;

  debounce_sync #(
    .STABLE_CYCLES (4),
    .CNT_W         (8),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clock  (clk),
    .reset  (reset),
    .din    (din),
    .enable (enable),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  debounce_sync #(
    .STABLE_CYCLES (1),
    .CNT_W         (8),
    .RESET_LEVEL   (1'b0)
  ) dut1 (
    .clock  (clk),
    .reset  (reset),
    .din    (din1),
    .enable (1'b1),
    .dout   (dout1),
    .rise   (rise1),
    .fall   (fall1),
    .busy   (busy1)
  );

  typedef struct {
    logic       din;
    logic       en;
    logic       rst;
    logic [3:0] exp; // {dout, rise, fall, busy}
  } vec_t;

  vec_t vecs[$];

  // Global invariants sampled away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if ((rise && fall) || (rise1 && fall1)) viol_both++;
      if (busy1) viol_busy1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic d, input logic e, input logic r, input logic [3:0] x);
    vec_t v;
    v.din = d; v.en = e; v.rst = r; v.exp = x;
    vecs.push_back(v);
  endtask

  // Waits (bounded) for dout to reach lvl; n = edges taken, 0 on timeout
  task automatic wait_dout(input logic lvl, output int n, output int rs, output int fs);
    n = 0; rs = 0; fs = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      rs += int'(rise);
      fs += int'(fall);
      if (dout === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, rs, fs, acc_p, acc_d, acc_b;
    logic [3:0] obs;

    din = 1'b1; enable = 1'b1; reset = 1'b1; din1 = 1'b0;

    // Reset, clean rise, clean fall
    add(1, 1, 1, 4'b0000);
    add(1, 1, 1, 4'b0000);
    add(1, 1, 0, 4'b0000); // E1
    add(1, 1, 0, 4'b0000); // E2
    add(1, 1, 0, 4'b0001); // E3
    add(1, 1, 0, 4'b0001); // E4
    add(1, 1, 0, 4'b0001); // E5
    add(1, 1, 0, 4'b1100); // E6
    for (int i = 7; i <= 10; i++) add(1, 1, 0, 4'b1000);
    add(0, 1, 0, 4'b1000); // E11
    add(0, 1, 0, 4'b1000);
    add(0, 1, 0, 4'b1001);
    add(0, 1, 0, 4'b1001);
    add(0, 1, 0, 4'b1001);
    add(0, 1, 0, 4'b0010); // E16
    for (int i = 17; i <= 20; i++) add(0, 1, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      din = vecs[i].din; enable = vecs[i].en; reset = vecs[i].rst;
      tick();
      if (i == 1) mon_en = 1'b1;
      obs = {dout, rise, fall, busy};
      total++;
      if (obs !== vecs[i].exp)
        $display("FAIL vec%0d {dout,rise,fall,busy}: got %b expected %b", i, obs, vecs[i].exp);
      else passed++;
    end

    // Glitch shorter than qualification window
    din = 1'b1;
    repeat (3) tick();
    din = 1'b0;
    acc_p = 0; acc_d = 0; acc_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc_p += int'(rise) + int'(fall);
      acc_d += int'(dout);
      acc_b += int'(busy);
    end
    check("glitch_busy_seen", int'(acc_b > 0), 1);
    check("glitch_pulses", acc_p, 0);
    check("glitch_dout", acc_d, 0);
    check("glitch_busy_end", int'(busy), 0);

    // Bounce 1,0,1,0,1 then hold 1
    acc_p = 0;
    din = 1'b1; tick(); acc_p += int'(rise);
    din = 1'b0; tick(); acc_p += int'(rise);
    din = 1'b1; tick(); acc_p += int'(rise);
    din = 1'b0; tick(); acc_p += int'(rise);
    din = 1'b1;
    wait_dout(1'b1, n, rs, fs);
    check("bounce_latency", n, 6);
    check("bounce_rise_count", acc_p + rs, 1);
    tick();
    check("bounce_rise_one_cycle", int'(rise), 0);
    din = 1'b0;
    wait_dout(1'b0, n, rs, fs);
    check("bounce_fall_latency", n, 6);
    check("bounce_fall_count", fs, 1);
    repeat (2) tick();

    // Enable freeze with cnt = 2
    din = 1'b1;
    repeat (4) tick();
    check("freeze_in_check", int'(busy), 1);
    enable = 1'b0;
    acc_p = 0; acc_d = 0; acc_b = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc_p += int'(rise) + int'(fall);
      acc_d += int'(dout);
      acc_b += int'(busy);
    end
    check("freeze_pulses", acc_p, 0);
    check("freeze_dout", acc_d, 0);
    check("freeze_busy_held", acc_b, 5);
    enable = 1'b1;
    wait_dout(1'b1, n, rs, fs);
    check("freeze_total_latency", 4 + 5 + n, 11);
    check("freeze_rise", rs, 1);
    din = 1'b0;
    wait_dout(1'b0, n, rs, fs);
    check("freeze_fall_latency", n, 6);
    repeat (2) tick();

    // Reset while in CHECK with cnt = 3
    din = 1'b1;
    repeat (5) tick();
    check("midreset_in_check", int'(busy), 1);
    reset = 1'b1; din = 1'b0;
    tick();
    check("midreset_outputs", int'({dout, rise, fall, busy}), 0);
    reset = 1'b0;
    acc_p = 0; acc_d = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc_p += int'(rise) + int'(fall);
      acc_d += int'(dout);
    end
    check("midreset_pulses", acc_p, 0);
    check("midreset_dout", acc_d, 0);

    // Minimum setting STABLE_CYCLES = 1
    din1 = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dout1 === 1'b1) begin n = i; break; end
    end
    check("sc1_rise_latency", n, 3);
    check("sc1_rise_pulse", int'(rise1), 1);
    tick();
    check("sc1_rise_one_cycle", int'({dout1, rise1}), 2);
    din1 = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dout1 === 1'b0) begin n = i; break; end
    end
    check("sc1_fall_latency", n, 3);
    check("sc1_fall_pulse", int'(fall1), 1);
    tick();

    mon_en = 1'b0;
    check("rise_fall_exclusive", viol_both, 0);
    check("sc1_busy_never", viol_busy1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
